// File: rtl/c2h_desc_ring_gen.sv
// c2h_desc_ring_gen
// Feeds the XDMA C2H engine in descriptor-bypass mode from a fixed host ring.
// One descriptor (one ring slot) is issued per upstream packet. The packet is
// then passed straight through to S_AXIS_C2H. The host hands consumed slots
// back as credits, so no more than RING_SLOTS slots are ever in flight.
//
// Optional feature: define C2H_DESC_STATS_EN to add the stat_pkts and
// stat_stall_cycles counters. Without it those ports do not exist.
//
// Handshake semantics: a transfer on any valid/ready pair happens in a cycle
// where both are high at the rising clock edge. A source holds valid and its
// payload stable until that transfer happens. For the descriptor port,
// dsc_byp_load is the "valid", and it is raised only in cycles where XDMA
// already shows dsc_byp_ready. Every load pulse is therefore an accepted
// descriptor.
module c2h_desc_ring_gen #(
    parameter logic [63:0] RING_BASE  = 64'h1_0000_0000,
    parameter int          RING_SLOTS = 16,
    parameter logic [27:0] SLOT_BYTES = 28'h1000,
    parameter int          DATA_WIDTH = 256
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    // upstream C2H stream
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    // stream to XDMA S_AXIS_C2H
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    // XDMA C2H descriptor bypass
    output logic [63:0]               dsc_byp_dst_addr,
    output logic [63:0]               dsc_byp_src_addr,
    output logic [27:0]               dsc_byp_len,
    output logic [15:0]               dsc_byp_ctl,
    input  logic                      dsc_byp_ready,
    output logic                      dsc_byp_load,
    // host credit return and link status
    input  logic                      credit_valid,
    input  logic [7:0]                credit_cnt,
    input  logic                      link_up,
    output logic [8:0]                outstanding,
    // FSM state for debug and checkers: 0 IDLE, 1 LOAD, 2 STREAM
    output logic [1:0]                o_dbg_state
`ifdef C2H_DESC_STATS_EN
    ,
    output logic [31:0]               stat_pkts,
    output logic [31:0]               stat_stall_cycles
`endif
);

    localparam int          SLOT_W        = (RING_SLOTS > 1) ? $clog2(RING_SLOTS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RING_SLOTS - 1);
    localparam logic [8:0]  SLOTS_9       = 9'(RING_SLOTS);
    localparam logic [63:0] SLOT_BYTES_64 = {36'd0, SLOT_BYTES};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_wr_slot;
    logic [8:0]          r_outstanding;

    logic                w_in_stream;
    logic                w_accept;
    logic                w_pkt_end;
    logic                w_room;
    logic [SLOT_W-1:0]   w_slot_next;
    logic [63:0]         w_slot_64;
    logic [8:0]          w_out_inc;
    logic [8:0]          w_out_next;

    assign w_in_stream = (r_state == ST_STREAM);
    // The descriptor is taken in the first LOAD cycle where XDMA is ready and
    // the link is still up. If the link drops first, no load is issued.
    assign w_accept    = (r_state == ST_LOAD) && link_up && dsc_byp_ready;
    assign w_pkt_end   = w_in_stream && s_tvalid && m_tready && s_tlast;
    assign w_room      = (r_outstanding < SLOTS_9);
    assign w_slot_next = (r_wr_slot == SLOT_LAST) ? '0 : r_wr_slot + SLOT_W'(1);

    // The slot address comes from the slot index alone. It cannot change
    // while a descriptor is being offered.
    assign w_slot_64        = {{(64-SLOT_W){1'b0}}, r_wr_slot};
    assign dsc_byp_dst_addr = RING_BASE + w_slot_64 * SLOT_BYTES_64;
    assign dsc_byp_src_addr = 64'd0;
    assign dsc_byp_len      = SLOT_BYTES;
    assign dsc_byp_ctl      = 16'd0;
    // The load pulse must follow dsc_byp_ready in the same cycle, so it is
    // combinational rather than registered.
    assign dsc_byp_load     = w_accept;

    // Packets are passed through with zero latency. Outside STREAM the
    // upstream sees ready low, so it holds its beat until a slot is granted.
    // No beat is lost.
    assign m_tvalid = w_in_stream && s_tvalid;
    assign s_tready = w_in_stream && m_tready;
    assign m_tdata  = s_tdata;
    assign m_tkeep  = s_tkeep;
    assign m_tlast  = s_tlast;

    assign outstanding = r_outstanding;
    assign o_dbg_state = r_state;

    // Net in-flight slot count: add one for an acceptance, then take off the
    // returned credits. The result saturates at zero.
    always_comb begin
        w_out_inc  = r_outstanding + {8'd0, w_accept};
        w_out_next = w_out_inc;
        if (credit_valid) begin
            if (w_out_inc > {1'b0, credit_cnt}) begin
                w_out_next = w_out_inc - {1'b0, credit_cnt};
            end else begin
                w_out_next = '0;
            end
        end
    end

    // Control FSM: wait for a packet and a free slot, issue its descriptor,
    // then stream the packet through until tlast.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_wr_slot     <= '0;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
            case (r_state)
                ST_IDLE: begin
                    if (s_tvalid && link_up && w_room) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!link_up) begin
                        r_state <= ST_IDLE;
                    end else if (dsc_byp_ready) begin
                        r_state   <= ST_STREAM;
                        r_wr_slot <= w_slot_next;
                    end
                end
                ST_STREAM: begin
                    // Link loss does not cut a packet short. The packet runs
                    // to its tlast.
                    if (w_pkt_end) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef C2H_DESC_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_stall;

    // Count completed packets, and count cycles where a packet waits because
    // the ring is full. Both counters wrap.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_stat_pkts  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pkt_end) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
            if ((r_state == ST_IDLE) && s_tvalid && (r_outstanding == SLOTS_9)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_pkts         = r_stat_pkts;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: doc/c2h_desc_ring_gen.md
C2H_DESC_RING_GEN -- requirements
Module: c2h_desc_ring_gen

Interface
REQ-001 SHALL have parameter RING_BASE, default 64'h100000000, host physical base of the reserved C2H ring.
REQ-002 SHALL have parameter RING_SLOTS, default 16, number of slots; power of two, 2..256.
REQ-003 SHALL have parameter SLOT_BYTES, default 28'h1000, bytes per slot and descriptor length.
REQ-004 SHALL have parameter DATA_WIDTH, default 256.
REQ-005 clk  in  1  single clock (user_clk_250 domain); rising edge.
REQ-006 sys_rst  in  1  reset; synchronous, active-high.
REQ-007 s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast  in/out/in/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8/1  upstream C2H stream.
REQ-008 m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  stream to XDMA S_AXIS_C2H.
REQ-009 dsc_byp_dst_addr  out  64; dsc_byp_src_addr out 64 (tied 0); dsc_byp_len out 28 (SLOT_BYTES); dsc_byp_ctl out 16 (tied 0).
REQ-010 dsc_byp_ready  in  1; dsc_byp_load  out  1  XDMA C2H descriptor-bypass handshake.
REQ-011 credit_valid  in  1; credit_cnt  in  8  host returns credit_cnt consumed slots.
REQ-012 link_up  in  1  descriptors issued only while high.
REQ-013 outstanding  out  9  slots issued and not yet credited.

Function
REQ-014 SHALL implement states IDLE, LOAD, STREAM.
REQ-015 IDLE -> LOAD when s_tvalid=1, link_up=1, outstanding<RING_SLOTS; else stay.
REQ-016 In LOAD, dsc_byp_load SHALL be 1 exactly in cycles where dsc_byp_ready=1; first such cycle is acceptance, next state STREAM.
REQ-017 dsc_byp_dst_addr SHALL equal RING_BASE + wr_slot*SLOT_BYTES, stable throughout LOAD.
REQ-018 On acceptance, wr_slot SHALL increment modulo RING_SLOTS (RING_SLOTS-1 -> 0) and outstanding SHALL increment.
REQ-019 In STREAM, m_* SHALL be combinational pass-through of s_*; s_tready=m_tready; zero added latency.
REQ-020 Outside STREAM, m_tvalid=0 and s_tready=0 (upstream stalled, no beat lost).
REQ-021 STREAM -> IDLE on beat with m_tvalid&m_tready&m_tlast; exactly one descriptor per packet.
REQ-022 Packets longer than SLOT_BYTES SHALL still pass; no truncation, no extra descriptor.
REQ-023 credit_valid SHALL subtract credit_cnt from outstanding, saturating at 0.
REQ-024 Simultaneous acceptance and credit SHALL apply net outstanding + 1 - credit_cnt in one cycle.
REQ-025 outstanding==RING_SLOTS SHALL block IDLE->LOAD until a credit arrives.
REQ-026 link_up falling in LOAD SHALL return to IDLE without issuing load; in STREAM, packet SHALL complete.

Reset
REQ-027 sys_rst=1 SHALL force IDLE, wr_slot=0, outstanding=0, dsc_byp_load=0, m_tvalid=0, s_tready=0 on next edge.
REQ-028 Reset mid-packet SHALL abandon the packet; no tlast emitted by this block.

Configuration
REQ-029 With C2H_DESC_STATS_EN defined, SHALL add outputs stat_pkts (32) and stat_stall_cycles (32): packets completed, and cycles in IDLE with s_tvalid=1 and outstanding==RING_SLOTS; both wrap, cleared by sys_rst.
REQ-030 Without C2H_DESC_STATS_EN, those ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-031 Reset, dsc_byp_ready=1, 3-beat packet -> one load pulse, dst_addr 64'h100000000, len 28'h1000, 3 beats out, outstanding=1.
REQ-032 17 packets, no credits, RING_SLOTS=16 -> 16 loads, 17th stalls (s_tready=0), outstanding=16; credit_cnt=1 -> 17th load, dst_addr 64'h100000000 (wrap).
REQ-033 dsc_byp_ready held 0 for 10 cycles in LOAD -> load stays 0, no beats pass; ready=1 -> single load, then stream.
REQ-034 Credit_cnt=2 same cycle as acceptance with outstanding=5 -> outstanding=4.
REQ-035 sys_rst asserted during beat 2 of 4 -> IDLE, outstanding=0, next descriptor dst_addr 64'h100000000.
REQ-036 m_tready toggled 1/0 during 8-beat packet -> all 8 beats delivered in order, data/keep/last unchanged.
